// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access owner and
// the latency-counter width helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } owner_e;

  // Counter must hold MEM_LAT-1; +1 keeps MEM_LAT=1 at a one-bit counter.
  function automatic int unsigned lat_w(input int unsigned mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core data port, the external loader/debug port and the
// single-port memory side; slave is the arbiter's view, master the rest.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_grant.sv
// Combinational grant between core and external port. DMEM_ARB_RR_EN selects
// round-robin on ties (using the last grant); otherwise the core always wins.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ext_req_i,
`ifdef DMEM_ARB_RR_EN
  input  owner_e last_i,
`endif
  output logic   gnt_o,
  output owner_e owner_o
);

  always_comb begin
    gnt_o   = cpu_req_i | ext_req_i;
    owner_o = OWN_CPU;
`ifdef DMEM_ARB_RR_EN
    if (cpu_req_i && ext_req_i) begin
      owner_o = (last_i == OWN_CPU) ? OWN_EXT : OWN_CPU;
    end else if (ext_req_i) begin
      owner_o = OWN_EXT;
    end
`else
    if (!cpu_req_i && ext_req_i) begin
      owner_o = OWN_EXT;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency single-port data memory between the core and an
// external port; stalls the core until its access completes. DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned      LAT_W    = lat_w(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              gnt;
  owner_e            gnt_owner;

`ifdef DMEM_ARB_RR_EN
  owner_e            last_q, last_d;
`endif

  dmem_arb_grant u_grant (
    .cpu_req_i (bus.cpu_req),
    .ext_req_i (bus.ext_req),
`ifdef DMEM_ARB_RR_EN
    .last_i    (last_q),
`endif
    .gnt_o     (gnt),
    .owner_o   (gnt_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Resets to EXT so the first tie after reset goes to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_EXT;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = ACCESS;
          owner_d = gnt_owner;
          cnt_d   = LAT_LOAD;
`ifdef DMEM_ARB_RR_EN
          last_d  = gnt_owner;
`endif
          if (gnt_owner == OWN_CPU) begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end else begin
            we_d    = bus.ext_we;
            addr_d  = bus.ext_addr;
            wdata_d = bus.ext_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWN_CPU) begin
              cpu_rdata_d = bus.mem_rdata;
            end else begin
              ext_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign bus.ext_ack   = (state_q == DONE) && (owner_q == OWN_EXT);
  assign bus.cpu_stall = bus.cpu_req && !((state_q == DONE) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized
// concurrent core/external traffic against a shadow-memory reference.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment memory: initial contents are a fixed function of the address.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (rst && bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    bus1.mem_rdata = 32'hCAFE_0000 | bus1.mem_addr;
  end

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } glog_t;

  exp_t  cpu_q[$];
  exp_t  ext_q[$];
  glog_t glog[$];

  // Completion monitors: pop the expected response when the DUT finishes.
  always @(negedge clk) begin : mon_done
    exp_t e;
    if (rst) begin
      if (bus.cpu_req && !bus.cpu_stall) begin
        if (cpu_q.size() == 0) begin
          check("cpu_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = cpu_q.pop_front();
          if (e.rd) check("cpu_rdata", bus.cpu_rdata, e.data);
        end
      end
      if (bus.ext_ack) begin
        ack_cnt++;
        if (ext_q.size() == 0) begin
          check("ext_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = ext_q.pop_front();
          if (e.rd) check("ext_rdata", bus.ext_rdata, e.data);
        end
      end
    end
  end

  // Memory-side monitor: burst length, address stability, ack width, grant log.
  int unsigned burst = 0;
  logic [31:0] burst_addr = '0;
  logic        ack_prev = 1'b0;
  always @(negedge clk) begin : mon_mem
    glog_t g;
    if (!rst) begin
      burst    = 0;
      ack_prev = 1'b0;
    end else begin
      if (bus.mem_en) begin
        if (burst == 0) begin
          burst_addr = bus.mem_addr;
          g.cyc = cyc; g.addr = bus.mem_addr; g.we = bus.mem_we; g.wdata = bus.mem_wdata;
          glog.push_back(g);
        end else begin
          check("mem_addr_stable", bus.mem_addr, burst_addr);
        end
        burst++;
      end else if (burst != 0) begin
        check("mem_en_len", 32'(burst), 32'(LAT));
        burst = 0;
      end
      if (bus.ext_ack) check("ext_ack_pulse", 32'(ack_prev), 32'd0);
      ack_prev = bus.ext_ack;
    end
  end

  // Core behaviour: request held until stall drops, then advance on that edge.
  task automatic cpu_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                            output int stall_cyc);
    exp_t e;
    logic ok;
    e.rd = !we;
    e.data = ref_rd(a);
    if (we) ref_mem[a] = d;
    cpu_q.push_back(e);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    stall_cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin ok = 1'b1; break; end
      stall_cyc++;
    end
    if (!ok) begin
      check("cpu_timeout", 32'd0, 32'd1);
      void'(cpu_q.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic ext_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic ok;
    e.rd = !we;
    e.data = ref_rd(a);
    if (we) ref_mem[a] = d;
    ext_q.push_back(e);
    bus.ext_req = 1'b1; bus.ext_we = we; bus.ext_addr = a; bus.ext_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.ext_ack) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("ext_timeout", 32'd0, 32'd1);
      void'(ext_q.pop_back());
    end
    @(posedge clk); #1;
    bus.ext_req = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    int s0, s1, s2;
    int unsigned cnt, acks;
    logic found;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.ext_req = 0; bus1.ext_we = 0; bus1.ext_addr = '0; bus1.ext_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_en",    32'(bus.mem_en),  32'd0);
    check("rst_mem_we",    32'(bus.mem_we),  32'd0);
    check("rst_mem_addr",  bus.mem_addr,     32'd0);
    check("rst_mem_wdata", bus.mem_wdata,    32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata,    32'd0);
    check("rst_ext_rdata", bus.ext_rdata,    32'd0);
    check("rst_ext_ack",   32'(bus.ext_ack), 32'd0);
    check("rst_stall_lo",  32'(bus.cpu_stall), 32'd0);
    bus.cpu_req = 1'b1; #1;
    check("rst_stall_hi",  32'(bus.cpu_stall), 32'd1);
    bus.cpu_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single core read
    mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    glog.delete();
    cpu_access(1'b0, 32'h10, 32'h0, s0);
    bus.cpu_req = 1'b0;
    check("t1_stall_cycles", 32'(s0), 32'(LAT + 1));
    check("t1_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    check("t1_grants", 32'(glog.size()), 32'd1);
    if (glog.size() == 1) begin
      check("t1_addr", glog[0].addr, 32'h10);
      check("t1_we",   32'(glog[0].we), 32'd0);
    end

    // External write
    glog.delete();
    acks = ack_cnt;
    ext_access(1'b1, 32'h20, 32'h1234);
    check("t2_stall", 32'(bus.cpu_stall), 32'd0);
    repeat (4) @(posedge clk); #1;
    check("t2_ack_count", ack_cnt - acks, 32'd1);
    check("t2_grants", 32'(glog.size()), 32'd1);
    if (glog.size() == 1) begin
      check("t2_addr",  glog[0].addr,  32'h20);
      check("t2_we",    32'(glog[0].we), 32'd1);
      check("t2_wdata", glog[0].wdata, 32'h1234);
    end

    // Reset during the first access cycle
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h300; bus.ext_wdata = 32'hFFFF;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin found = 1'b1; break; end
    end
    check("t4_access_seen", 32'(found), 32'd1);
    rst = 1'b0; #1;
    check("t4_mem_en",    32'(bus.mem_en), 32'd0);
    check("t4_mem_we",    32'(bus.mem_we), 32'd0);
    check("t4_mem_addr",  bus.mem_addr,    32'd0);
    check("t4_mem_wdata", bus.mem_wdata,   32'd0);
    check("t4_cpu_rdata", bus.cpu_rdata,   32'd0);
    check("t4_ext_ack",   32'(bus.ext_ack), 32'd0);
    bus.ext_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_en || bus.ext_ack) cnt++;
    end
    check("t4_quiet", cnt, 32'd0);
    @(posedge clk); #1;

    // Simultaneous requests: core issues two reads, ext one
    glog.delete();
    fork
      begin
        cpu_access(1'b0, 32'h40, 32'h0, s1);
        cpu_access(1'b0, 32'h44, 32'h0, s2);
        bus.cpu_req = 1'b0;
      end
      ext_access(1'b0, 32'h140, 32'h0);
    join
    check("t3_grants", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      check("t3_g0", glog[0].addr, 32'h40);
`ifdef DMEM_ARB_RR_EN
      check("t3_g1", glog[1].addr, 32'h140);
      check("t3_g2", glog[2].addr, 32'h44);
`else
      check("t3_g1", glog[1].addr, 32'h44);
      check("t3_g2", glog[2].addr, 32'h140);
`endif
    end

    // Back-to-back core reads
    repeat (2) @(posedge clk); #1;
    glog.delete();
    cpu_access(1'b0, 32'h0, 32'h0, s1);
    cpu_access(1'b0, 32'h4, 32'h0, s2);
    bus.cpu_req = 1'b0;
    check("t5_stall0", 32'(s1), 32'(LAT + 1));
    check("t5_stall1", 32'(s2), 32'(LAT + 1));
    check("t5_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) check("t5_spacing", glog[1].cyc - glog[0].cyc, 32'(LAT + 2));

    // MEM_LAT = 1 instance
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h8;
    s0 = 0; cnt = 0; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.mem_en) cnt++;
      if (!bus1.cpu_stall) begin
        found = 1'b1;
        check("t6_rdata", bus1.cpu_rdata, 32'hCAFE_0008);
        break;
      end
      s0++;
    end
    check("t6_done",   32'(found), 32'd1);
    check("t6_stall",  32'(s0), 32'd2);
    check("t6_mem_en", cnt, 32'd1);
    @(posedge clk); #1;
    bus1.cpu_req = 1'b0;

    // Random concurrent traffic, core in 0x000-0x0FC, external in 0x100-0x1FC
    fork
      begin
        repeat (60) begin
          bus.cpu_req = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          cpu_access(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 63)), 2'b00},
                     $urandom, s0);
        end
        bus.cpu_req = 1'b0;
      end
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          ext_access(1'($urandom_range(0, 1)), 32'h100 | {22'd0, 8'($urandom_range(0, 63)), 2'b00},
                     $urandom);
        end
      end
    join
    repeat (10) @(posedge clk); #1;
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("ext_q_drained", 32'(ext_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
